// File: rtl/aes_mode.sv
// aes_mode: ECB/CBC block-mode wrapper driving an external AES core, one block in flight.
// Build option: define AES_MODE_CTR_EN to include CTR mode and its counter register.
`default_nettype none

module aes_mode #(
   parameter int NK    = 4,
   parameter int KW    = 32*NK,
   parameter int CTR_W = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           cfg_valid,
   input  logic [1:0]     cfg_mode,
   input  logic           cfg_dir,
   input  logic [KW-1:0]  cfg_key,
   input  logic [127:0]   cfg_iv,
   output logic           cfg_ready,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [127:0]   in_data,
   input  logic           in_last,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [127:0]   out_data,
   output logic           out_last,
   output logic           err,
   output logic           core_enable,
   output logic [1:0]     core_func,
   output logic [KW-1:0]  core_key,
   output logic [127:0]   core_data,
   input  logic           core_ready,
   input  logic [127:0]   core_result
);

   localparam logic [1:0] MODE_ECB     = 2'd0;
   localparam logic [1:0] MODE_CBC     = 2'd1;
   localparam logic [1:0] FUNC_KEXP    = 2'd1;
   localparam logic [1:0] FUNC_CIPHER  = 2'd2;
   localparam logic [1:0] FUNC_ICIPHER = 2'd3;
`ifdef AES_MODE_CTR_EN
   localparam logic [1:0]   MODE_CTR     = 2'd2;
   localparam logic [127:0] CTR_LOW_MASK = (CTR_W >= 128) ? {128{1'b1}}
                                         : ((128'd1 << CTR_W) - 128'd1);
`endif

   generate
      if (CTR_W < 1 || CTR_W > 128) begin : g_bad_ctr_w
         $error("aes_mode: CTR_W must be within 1..128");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      KEXP  = 3'd1,
      READY = 3'd2,
      BUSY  = 3'd3,
      OUT   = 3'd4
   } state_t;

   state_t         state_reg, state_next;
   logic [1:0]     mode_reg, mode_next;
   logic           dir_reg, dir_next;
   logic [KW-1:0]  key_reg, key_next;
   logic [127:0]   iv_reg, iv_next;
   logic [127:0]   chain_reg, chain_next;
   logic [127:0]   data_reg, data_next;
   logic           last_reg, last_next;
   logic [127:0]   out_data_reg, out_data_next;
   logic           out_last_reg, out_last_next;
   logic           err_reg, err_next;
`ifdef AES_MODE_CTR_EN
   logic [127:0]   ctr_reg, ctr_next;
   logic [127:0]   ctr_inc;
`endif

   logic           mode_ok;
   logic           cfg_fire;
   logic           in_fire;
   logic [1:0]     block_func;
   logic [127:0]   block_data;
   logic [127:0]   result_mix;

   // Handshake qualifiers; a pending config wins over an input block in READY.
   assign cfg_ready = (state_reg == IDLE) || (state_reg == READY);
   assign cfg_fire  = cfg_valid && cfg_ready;
   assign in_ready  = (state_reg == READY) && !cfg_valid;
   assign in_fire   = in_valid && in_ready;
   assign out_valid = (state_reg == OUT);
   assign out_data  = out_data_reg;
   assign out_last  = out_last_reg;
   assign err       = err_reg;

   always_comb begin
      mode_ok = (cfg_mode == MODE_ECB) || (cfg_mode == MODE_CBC);
`ifdef AES_MODE_CTR_EN
      if (cfg_mode == MODE_CTR) mode_ok = 1'b1;
`endif
   end

`ifdef AES_MODE_CTR_EN
   // Only the low CTR_W bits count; the carry out of that field is dropped.
   assign ctr_inc = (ctr_reg & ~CTR_LOW_MASK) | ((ctr_reg + 128'd1) & CTR_LOW_MASK);
`endif

   // Core request contents for the block being accepted this cycle.
   always_comb begin
      block_func = dir_reg ? FUNC_ICIPHER : FUNC_CIPHER;
      block_data = in_data;
      if (mode_reg == MODE_CBC && !dir_reg) begin
         block_data = in_data ^ chain_reg;
      end
`ifdef AES_MODE_CTR_EN
      if (mode_reg == MODE_CTR) begin
         block_func = FUNC_CIPHER;
         block_data = ctr_reg;
      end
`endif
   end

   // Post-processing of the core result into the output block.
   always_comb begin
      result_mix = core_result;
      if (mode_reg == MODE_CBC && dir_reg) begin
         result_mix = core_result ^ chain_reg;
      end
`ifdef AES_MODE_CTR_EN
      if (mode_reg == MODE_CTR) begin
         result_mix = core_result ^ data_reg;
      end
`endif
   end

   always_comb begin
      core_enable = 1'b0;
      core_func   = 2'd0;
      core_key    = '0;
      core_data   = '0;
      if (state_reg == KEXP) begin
         core_enable = 1'b1;
         core_func   = FUNC_KEXP;
         core_key    = key_reg;
      end else if (in_fire) begin
         core_enable = 1'b1;
         core_func   = block_func;
         core_key    = key_reg;
         core_data   = block_data;
      end
   end

   always_comb begin
      state_next    = state_reg;
      mode_next     = mode_reg;
      dir_next      = dir_reg;
      key_next      = key_reg;
      iv_next       = iv_reg;
      chain_next    = chain_reg;
      data_next     = data_reg;
      last_next     = last_reg;
      out_data_next = out_data_reg;
      out_last_next = out_last_reg;
      err_next      = 1'b0;
`ifdef AES_MODE_CTR_EN
      ctr_next      = ctr_reg;
`endif
      case (state_reg)
         IDLE, READY: begin
            if (cfg_fire) begin
               if (mode_ok) begin
                  mode_next  = cfg_mode;
                  dir_next   = cfg_dir;
                  key_next   = cfg_key;
                  iv_next    = cfg_iv;
                  chain_next = cfg_iv;
`ifdef AES_MODE_CTR_EN
                  ctr_next   = cfg_iv;
`endif
                  state_next = KEXP;
               end else begin
                  err_next = 1'b1;
               end
            end else if (in_fire) begin
               data_next  = in_data;
               last_next  = in_last;
               state_next = BUSY;
            end
         end
         KEXP: begin
            state_next = READY;
         end
         BUSY: begin
            if (core_ready) begin
               out_data_next = result_mix;
               out_last_next = last_reg;
               state_next    = OUT;
               if (mode_reg == MODE_CBC) begin
                  chain_next = dir_reg ? data_reg : core_result;
               end
`ifdef AES_MODE_CTR_EN
               if (mode_reg == MODE_CTR) begin
                  ctr_next = ctr_inc;
               end
`endif
            end
         end
         OUT: begin
            if (out_ready) begin
               state_next = READY;
               // A finished message restarts chaining from the configured IV.
               if (out_last_reg) begin
                  chain_next = iv_reg;
`ifdef AES_MODE_CTR_EN
                  ctr_next   = iv_reg;
`endif
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg    <= IDLE;
         mode_reg     <= '0;
         dir_reg      <= 1'b0;
         key_reg      <= '0;
         iv_reg       <= '0;
         chain_reg    <= '0;
         data_reg     <= '0;
         last_reg     <= 1'b0;
         out_data_reg <= '0;
         out_last_reg <= 1'b0;
         err_reg      <= 1'b0;
`ifdef AES_MODE_CTR_EN
         ctr_reg      <= '0;
`endif
      end else begin
         state_reg    <= state_next;
         mode_reg     <= mode_next;
         dir_reg      <= dir_next;
         key_reg      <= key_next;
         iv_reg       <= iv_next;
         chain_reg    <= chain_next;
         data_reg     <= data_next;
         last_reg     <= last_next;
         out_data_reg <= out_data_next;
         out_last_reg <= out_last_next;
         err_reg      <= err_next;
`ifdef AES_MODE_CTR_EN
         ctr_reg      <= ctr_next;
`endif
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_aes_mode.sv
// tb_aes_mode: randomized bench for aes_mode with a stand-in AES core and a mode-level reference model.
// Known-answer vectors are answered by table; other inputs use an invertible toy cipher.
`timescale 1ns/1ps

module tb_aes_mode;

   localparam logic [127:0] K1     = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT1    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT1    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K2     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] IV1    = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CP1    = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] CC1    = 128'h7649abac8119b246cee98e9b12e9197d;
   localparam logic [127:0] CP2    = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
   localparam logic [127:0] CC2    = 128'h5086cb9b507219ee95db113a917678b2;
   localparam logic [127:0] CTR_IV = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
   localparam logic [127:0] CTR_KS = 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
   localparam logic [127:0] TOYC   = 128'h3c6ef372a54ff53a510e527f9b05688c;

   logic          clk;
   logic          rst;
   logic          cfg_valid;
   logic [1:0]    cfg_mode;
   logic          cfg_dir;
   logic [127:0]  cfg_key;
   logic [127:0]  cfg_iv;
   logic          cfg_ready;
   logic          in_valid;
   logic          in_ready;
   logic [127:0]  in_data;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [127:0]  out_data;
   logic          out_last;
   logic          err;
   logic          core_enable;
   logic [1:0]    core_func;
   logic [127:0]  core_key;
   logic [127:0]  core_data;
   logic          core_ready;
   logic [127:0]  core_result;

   aes_mode dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_mode(cfg_mode), .cfg_dir(cfg_dir),
      .cfg_key(cfg_key), .cfg_iv(cfg_iv), .cfg_ready(cfg_ready),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .err(err),
      .core_enable(core_enable), .core_func(core_func), .core_key(core_key),
      .core_data(core_data), .core_ready(core_ready), .core_result(core_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, required %h", name, act, exp);
   endtask

   // Stand-in AES core: table for the published vectors, toy bijection otherwise.
   function automatic logic [127:0] aes_stub(input logic [1:0] f, input logic [127:0] k,
                                             input logic [127:0] d);
      logic [127:0] t;
      if (f == 2'd2) begin
         if (k == K1 && d == PT1) return CT1;
         if (k == K2 && d == (CP1 ^ IV1)) return CC1;
         if (k == K2 && d == (CP2 ^ CC1)) return CC2;
         if (k == K2 && d == CTR_IV) return CTR_KS;
         t = d ^ k;
         return {t[114:0], t[127:115]} ^ TOYC;
      end
      if (k == K1 && d == CT1) return PT1;
      t = d ^ TOYC;
      t = {t[12:0], t[127:13]};
      return t ^ k;
   endfunction

   int           core_lat = 1;
   logic [127:0] last_core_data = '0;

   initial begin
      logic [1:0]   f;
      logic [127:0] k;
      logic [127:0] d;
      int           lat;
      core_ready  = 1'b0;
      core_result = '0;
      forever begin
         @(negedge clk);
         if (rst && core_enable && core_func != 2'd1) begin
            f = core_func; k = core_key; d = core_data; lat = core_lat;
            last_core_data = d;
            repeat (lat) @(posedge clk);
            #1;
            core_ready  = 1'b1;
            core_result = aes_stub(f, k, d);
            @(posedge clk);
            #1;
            core_ready  = 1'b0;
            core_result = {$urandom, $urandom, $urandom, $urandom};
         end
      end
   end

   // Reference model: textbook mode equations over the stand-in cipher.
   typedef struct packed {
      logic [127:0] data;
      logic         last;
   } exp_t;

   exp_t         exp_q[$];
   logic [1:0]   m_mode;
   logic         m_dir;
   logic [127:0] m_key;
   logic [127:0] m_iv;
   logic [127:0] m_chain;

   task automatic model_push(input logic [127:0] p, input logic l);
      exp_t         e;
      logic [127:0] r;
      case (m_mode)
         2'd0: r = aes_stub(m_dir ? 2'd3 : 2'd2, m_key, p);
         2'd1: begin
            if (!m_dir) begin
               r = aes_stub(2'd2, m_key, p ^ m_chain);
               m_chain = r;
            end else begin
               r = aes_stub(2'd3, m_key, p) ^ m_chain;
               m_chain = p;
            end
         end
         default: begin
            r = p ^ aes_stub(2'd2, m_key, m_chain);
            m_chain[31:0] = m_chain[31:0] + 32'd1;
         end
      endcase
      if (l) m_chain = m_iv;
      e.data = r;
      e.last = l;
      exp_q.push_back(e);
   endtask

   // Output checker: every cycle out_valid is high the block must match the model.
   initial begin
      forever begin
         @(negedge clk);
         if (rst && out_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_out: out_valid=1 with no block pending, required 0");
            end else begin
               check("out_data", out_data, exp_q[0].data);
               check("out_last", {127'b0, out_last}, {127'b0, exp_q[0].last});
               check("in_ready_in_out", {127'b0, in_ready}, 128'd0);
               check("core_en_in_out", {127'b0, core_enable}, 128'd0);
               if (out_ready) begin
                  $display("block out %h last=%0d", out_data, out_last);
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   task automatic configure(input logic [1:0] mode, input logic dir, input logic [127:0] key,
                            input logic [127:0] iv, input logic expect_err);
      int n;
      @(posedge clk); #1;
      cfg_valid = 1'b1; cfg_mode = mode; cfg_dir = dir; cfg_key = key; cfg_iv = iv;
      n = 0;
      @(negedge clk);
      while (!cfg_ready && n < 50) begin @(negedge clk); n++; end
      check("cfg_ready_wait", {127'b0, cfg_ready}, 128'd1);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      @(negedge clk);
      $display("config mode=%0d dir=%0d err_expected=%0d", mode, dir, expect_err);
      if (expect_err) begin
         check("err_pulse", {127'b0, err}, 128'd1);
         check("err_no_kexp", {127'b0, core_enable}, 128'd0);
         @(posedge clk); @(negedge clk);
         check("err_one_cycle", {127'b0, err}, 128'd0);
         check("err_state_kept", {127'b0, in_ready}, 128'd1);
      end else begin
         check("kexp_en", {127'b0, core_enable}, 128'd1);
         check("kexp_func", {126'b0, core_func}, 128'd1);
         check("kexp_key", core_key, key);
         check("kexp_no_err", {127'b0, err}, 128'd0);
         @(posedge clk); @(negedge clk);
         check("kexp_one_cycle", {127'b0, core_enable}, 128'd0);
         check("ready_after_kexp", {127'b0, in_ready}, 128'd1);
         m_mode = mode; m_dir = dir; m_key = key; m_iv = iv; m_chain = iv;
      end
   endtask

   task automatic do_block(input logic [127:0] d, input logic l, input int hold, input int lat,
                           output logic [127:0] got);
      int           n;
      logic [1:0]   exp_func;
      logic [127:0] exp_cdata;
      got = '0;
      core_lat = lat;
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = d; in_last = l; out_ready = 1'b0;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      check("in_ready_wait", {127'b0, in_ready}, 128'd1);
      if (!in_ready) begin
         in_valid = 1'b0;
         return;
      end
      exp_func  = (m_mode != 2'd2 && m_dir) ? 2'd3 : 2'd2;
      exp_cdata = (m_mode == 2'd2) ? m_chain : ((m_mode == 2'd1 && !m_dir) ? (d ^ m_chain) : d);
      check("core_en_accept", {127'b0, core_enable}, 128'd1);
      check("core_func", {126'b0, core_func}, {126'b0, exp_func});
      check("core_data", core_data, exp_cdata);
      model_push(d, l);
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 1;
      @(negedge clk);
      while (!out_valid && n < 100) begin @(posedge clk); @(negedge clk); n++; end
      check("latency", n, lat + 1);
      if (!out_valid) begin
         exp_q.delete();
         return;
      end
      repeat (hold) begin @(posedge clk); @(negedge clk); end
      got = out_data;
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [127:0] got;
      logic [127:0] wiv;
      logic [127:0] exp_ctr;
      logic         ov_seen;
      int           nb;
      logic [1:0]   rmode;
      rst = 1'b0; cfg_valid = 1'b0; cfg_mode = '0; cfg_dir = 1'b0; cfg_key = '0; cfg_iv = '0;
      in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
      m_mode = '0; m_dir = 1'b0; m_key = '0; m_iv = '0; m_chain = '0;
      wiv = '0; exp_ctr = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", {127'b0, out_valid}, 128'd0);
      check("rst_in_ready", {127'b0, in_ready}, 128'd0);
      check("rst_err", {127'b0, err}, 128'd0);
      check("rst_core_en", {127'b0, core_enable}, 128'd0);
      check("rst_out_data", out_data, 128'd0);
      check("rst_cfg_ready", {127'b0, cfg_ready}, 128'd1);
      @(posedge clk); #1;
      rst = 1'b1;

      // Known-answer vectors.
      configure(2'd0, 1'b0, K1, 128'd0, 1'b0);
      do_block(PT1, 1'b1, 0, 3, got);
      check("ecb_enc_vec", got, CT1);
      configure(2'd0, 1'b1, K1, 128'd0, 1'b0);
      do_block(CT1, 1'b1, 2, 2, got);
      check("ecb_dec_vec", got, PT1);
      configure(2'd1, 1'b0, K2, IV1, 1'b0);
      do_block(CP1, 1'b0, 0, 1, got);
      check("cbc_vec1", got, CC1);
      do_block(CP2, 1'b1, 1, 4, got);
      check("cbc_vec2", got, CC2);
      do_block(CP1, 1'b1, 0, 2, got);
      check("cbc_iv_reload", got, CC1);

`ifdef AES_MODE_CTR_EN
      configure(2'd2, 1'b1, K2, CTR_IV, 1'b0);
      do_block(CP1, 1'b1, 0, 2, got);
      check("ctr_vec", got, 128'h874d6191b620e3261bef6864990db6ce);
      wiv = {96'h0123456789abcdef01234567, 32'hffffffff};
      configure(2'd2, 1'b0, K2, wiv, 1'b0);
      do_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, 1, got);
      do_block({$urandom, $urandom, $urandom, $urandom}, 1'b1, 0, 1, got);
      exp_ctr = wiv;
      exp_ctr[31:0] = 32'h0;
      check("ctr_wrap", last_core_data, exp_ctr);
`endif

      // Rejected configurations leave the CBC setup in place.
      configure(2'd1, 1'b0, K2, IV1, 1'b0);
      configure(2'd3, 1'b1, K1, PT1, 1'b1);
`ifndef AES_MODE_CTR_EN
      configure(2'd2, 1'b0, K1, PT1, 1'b1);
`endif
      do_block(CP1, 1'b1, 0, 1, got);
      check("cfg_reject_kept", got, CC1);

      // Ten cycles of output backpressure.
      configure(2'd0, 1'b0, K1, 128'd0, 1'b0);
      do_block({$urandom, $urandom, $urandom, $urandom}, 1'b1, 10, 3, got);

      // Random messages.
      for (int m = 0; m < 30; m++) begin
`ifdef AES_MODE_CTR_EN
         rmode = 2'($urandom_range(0, 2));
`else
         rmode = 2'($urandom_range(0, 1));
`endif
         wiv = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(0, 3) == 0) wiv[31:0] = 32'hffffffff;
         configure(rmode, 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
                   wiv, 1'b0);
         nb = $urandom_range(1, 4);
         for (int b = 0; b < nb; b++) begin
            do_block({$urandom, $urandom, $urandom, $urandom}, (b == nb - 1),
                     $urandom_range(0, 3), $urandom_range(1, 4), got);
         end
      end

      // Reset while BUSY, then a late core_ready.
      configure(2'd0, 1'b0, K1, 128'd0, 1'b0);
      core_lat = 4;
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = PT1; in_last = 1'b1;
      @(negedge clk);
      check("abort_accept", {127'b0, in_ready}, 128'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      $display("reset during BUSY applied");
      check("abort_out_valid", {127'b0, out_valid}, 128'd0);
      check("abort_cfg_ready", {127'b0, cfg_ready}, 128'd1);
      check("abort_in_ready", {127'b0, in_ready}, 128'd0);
      check("abort_core_en", {127'b0, core_enable}, 128'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      ov_seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) ov_seen = 1'b1;
      end
      check("late_ready_ignored", {127'b0, ov_seen}, 128'd0);
      check("late_ready_idle", {127'b0, cfg_ready}, 128'd1);
      configure(2'd1, 1'b0, K2, IV1, 1'b0);
      do_block(CP1, 1'b1, 0, 2, got);
      check("after_abort_cbc", got, CC1);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
